load_store_unit: RTL

//  Data-memory access stage downstream of the ALU: takes ALU_result as the effective address and

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// The request fields are held stable from request until mem_ack.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one req/ack data-memory access per start, with misalignment
// detection, a bus timeout and sign/zero-extended load data for the register file.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     is_store,
    input  logic [2:0]               funct3,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              rdata,
    output logic                     misalign,
    output logic                     fault,
    load_store_unit_if.master        mem
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t           state;
    logic             st_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;

    function automatic logic is_illegal(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic legal_f3;
        legal_f3 = st ? (f3 inside {3'd0, 3'd1, 3'd2})
                      : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal_f3 || (f3[1:0] == 2'd1 && off[0]) || (f3[1:0] == 2'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] bs;
        logic signed [31:0] hs;
        b  = w[8*off +: 8];
        h  = w[16*off[1] +: 16];
        bs = b;
        hs = h;
        case (f3)
            3'd0:    return bs;
            3'd1:    return hs;
            3'd4:    return {24'b0, b};
            3'd5:    return {16'b0, h};
            default: return w;
        endcase
    endfunction

    assign busy          = (state != IDLE);
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            st_q     <= 1'b0;
            f3_q     <= 3'd0;
            off_q    <= 2'd0;
            cnt      <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            rdata    <= 32'd0;
            done     <= 1'b0;
            misalign <= 1'b0;
            fault    <= 1'b0;
        end else begin
            done     <= 1'b0;
            misalign <= 1'b0;
            fault    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        st_q  <= is_store;
                        f3_q  <= funct3;
                        off_q <= addr[1:0];
                        if (is_illegal(is_store, funct3, addr[1:0])) begin
                            state    <= ERR;
                            done     <= 1'b1;
                            misalign <= 1'b1;
                        end else begin
                            state   <= REQ;
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {addr[31:2], 2'b00};
                            wdata_q <= store_lanes(funct3, wdata);
                            be_q    <= is_store ? store_be(funct3, addr[1:0]) : 4'b1111;
                        end
                    end
                end
                // Ack takes priority over the timeout on the last counted cycle.
                REQ: begin
                    if (mem.mem_ack) begin
                        state <= DONE;
                        done  <= 1'b1;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (!st_q)
                            rdata <= load_format(f3_q, off_q, mem.mem_rdata);
                    end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        fault <= 1'b1;
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
